// File: rtl/ps2_input_decoder.sv
// PS/2 Set-2 keyboard front end: it receives bytes, tracks E0/F0 prefixes, and maps
// make and break codes to ten held-key levels that are latched once per frame on SCEN.
module ps2_input_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       p1_left,
  output logic       p1_right,
  output logic       p1_jump,
  output logic       p1_atk1,
  output logic       p1_atk2,
  output logic       p2_left,
  output logic       p2_right,
  output logic       p2_jump,
  output logic       p2_atk1,
  output logic       p2_atk2,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, SHIFT} rx_state_t;
  typedef enum logic [1:0] {P_NONE, P_E0, P_F0, P_E0F0} pfx_state_t;

  logic            clk_s1, clk_s2, clk_d;
  logic            data_s1, data_s2, data_q;
  logic            strobe;
  rx_state_t       rx_state;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [WD_W-1:0] wd;
  pfx_state_t      pfx;
  logic [9:0]      key_held, key_seen, keys_out;
  logic            is_e0, is_f0, ext, brk, ev;
  logic [9:0]      key_mask, make_mask, brk_mask;

  // Both synchronisers reset to the PS/2 idle level so a reset does not produce a false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_d   <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      data_q  <= 1'b1;
      strobe  <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_d   <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      data_q  <= data_s2;
      strobe  <= clk_d & ~clk_s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state  <= IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      par_bit   <= 1'b0;
      wd        <= '0;
      rx_byte   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (strobe)
        wd <= '0;
      else if (wd != WD_MAX)
        wd <= wd + 1'b1;
      case (rx_state)
        IDLE: begin
          if (strobe && !data_q) begin
            rx_state <= SHIFT;
            bit_cnt  <= 4'd1;
          end
        end
        SHIFT: begin
          if (strobe) begin
            if (bit_cnt <= 4'd8) begin
              shreg   <= {data_q, shreg[7:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd9) begin
              par_bit <= data_q;
              bit_cnt <= bit_cnt + 4'd1;
            end else begin
              rx_state <= IDLE;
              bit_cnt  <= 4'd0;
              if ((^{shreg, par_bit}) && data_q) begin
                rx_byte  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end else if (wd == WD_MAX) begin
            // The sender stalled mid-frame, so drop the frame quietly.
            rx_state <= IDLE;
            bit_cnt  <= 4'd0;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  function automatic logic [9:0] key_lookup(input logic [7:0] code, input logic is_ext);
    logic [9:0] m;
    m = 10'd0;
    case ({is_ext, code})
      9'h01C:  m[0] = 1'b1;
      9'h023:  m[1] = 1'b1;
      9'h01D:  m[2] = 1'b1;
      9'h02B:  m[3] = 1'b1;
      9'h034:  m[4] = 1'b1;
      9'h16B:  m[5] = 1'b1;
      9'h174:  m[6] = 1'b1;
      9'h175:  m[7] = 1'b1;
      9'h042:  m[8] = 1'b1;
      9'h04B:  m[9] = 1'b1;
      default: m = 10'd0;
    endcase
    return m;
  endfunction

  always_comb begin
    is_e0     = (rx_byte == 8'hE0);
    is_f0     = (rx_byte == 8'hF0);
    ext       = (pfx == P_E0) || (pfx == P_E0F0);
    brk       = (pfx == P_F0) || (pfx == P_E0F0);
    ev        = rx_valid && !is_e0 && !is_f0;
    key_mask  = key_lookup(rx_byte, ext);
    make_mask = (ev && !brk) ? key_mask : 10'd0;
    brk_mask  = (ev && brk) ? key_mask : 10'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pfx <= P_NONE;
    end else if (frame_err) begin
      pfx <= P_NONE;
    end else if (rx_valid) begin
      if (is_e0)
        pfx <= P_E0;
      else if (is_f0) begin
        case (pfx)
          P_NONE:  pfx <= P_F0;
          P_E0:    pfx <= P_E0F0;
          default: pfx <= pfx;
        endcase
      end else
        pfx <= P_NONE;
    end
  end

  // The frame sample uses the pre-edge key state. A make that lands in the same cycle stays in key_seen for the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_held <= 10'd0;
      key_seen <= 10'd0;
      keys_out <= 10'd0;
    end else begin
      key_held <= (key_held | make_mask) & ~brk_mask;
      key_seen <= (SCEN ? 10'd0 : key_seen) | make_mask;
      if (SCEN)
        keys_out <= key_held | key_seen;
    end
  end

  assign p1_left  = keys_out[0];
  assign p1_right = keys_out[1];
  assign p1_jump  = keys_out[2];
  assign p1_atk1  = keys_out[3];
  assign p1_atk2  = keys_out[4];
  assign p2_left  = keys_out[5];
  assign p2_right = keys_out[6];
  assign p2_jump  = keys_out[7];
  assign p2_atk1  = keys_out[8];
  assign p2_atk2  = keys_out[9];

endmodule

// File: tb/tb_ps2_input_decoder.sv
// Directed bench for ps2_input_decoder. It sends PS/2 frames bit by bit and
// checks the frame-latched key outputs against hand-computed values.
module tb_ps2_input_decoder;
  localparam int TO = 300;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic SCEN = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic p1_left, p1_right, p1_jump, p1_atk1, p1_atk2;
  logic p2_left, p2_right, p2_jump, p2_atk1, p2_atk2;
  logic [7:0] rx_byte;
  logic rx_valid, frame_err;
  logic [9:0] outs;
  int checks = 0;
  int failures = 0;
  int rx_cnt = 0;
  int err_cnt = 0;

  ps2_input_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .SCEN(SCEN), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .p1_left(p1_left), .p1_right(p1_right), .p1_jump(p1_jump), .p1_atk1(p1_atk1),
    .p1_atk2(p1_atk2), .p2_left(p2_left), .p2_right(p2_right), .p2_jump(p2_jump),
    .p2_atk1(p2_atk1), .p2_atk2(p2_atk2), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  assign outs = {p2_atk2, p2_atk1, p2_jump, p2_right, p2_left,
                 p1_atk2, p1_atk1, p1_jump, p1_right, p1_left};

  always @(posedge clk) begin
    if (rx_valid) rx_cnt <= rx_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par);
    logic p;
    p = ~(^d) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_tick();
    @(negedge clk);
    SCEN = 1'b1;
    @(negedge clk);
    SCEN = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      frame_tick();
      checks++;
      if (outs !== 10'h000) begin
        failures++;
        $display("FAIL reset_outs tick=%0d got=%h exp=000", i, outs);
      end
    end
    checks++;
    if (rx_byte !== 8'h00) begin
      failures++;
      $display("FAIL reset_rx_byte got=%h exp=00", rx_byte);
    end
    checks++;
    if (rx_cnt !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL reset_pulses rx=%0d err=%0d exp=0/0", rx_cnt, err_cnt);
    end
  endtask

  task automatic test_make_break();
    send_byte(8'h1C, 1'b0);
    frame_tick();
    checks++;
    if (outs !== 10'h001) begin
      failures++;
      $display("FAIL make_1c got=%h exp=001", outs);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    frame_tick();
    checks++;
    if (outs !== 10'h000) begin
      failures++;
      $display("FAIL break_1c got=%h exp=000", outs);
    end
    checks++;
    if (rx_byte !== 8'h1C) begin
      failures++;
      $display("FAIL rx_byte_1c got=%h exp=1c", rx_byte);
    end
  endtask

  task automatic test_extended();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    frame_tick();
    checks++;
    if (outs !== 10'h020) begin
      failures++;
      $display("FAIL ext_make_6b got=%h exp=020", outs);
    end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    frame_tick();
    checks++;
    if (outs !== 10'h000) begin
      failures++;
      $display("FAIL ext_break_6b got=%h exp=000", outs);
    end
    send_byte(8'h6B, 1'b0);
    frame_tick();
    checks++;
    if (outs !== 10'h000) begin
      failures++;
      $display("FAIL plain_6b got=%h exp=000", outs);
    end
    checks++;
    if (rx_byte !== 8'h6B) begin
      failures++;
      $display("FAIL rx_byte_6b got=%h exp=6b", rx_byte);
    end
  endtask

  task automatic test_tap();
    send_byte(8'h23, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h23, 1'b0);
    frame_tick();
    checks++;
    if (outs !== 10'h002) begin
      failures++;
      $display("FAIL tap_seen got=%h exp=002", outs);
    end
    frame_tick();
    checks++;
    if (outs !== 10'h000) begin
      failures++;
      $display("FAIL tap_cleared got=%h exp=000", outs);
    end
  endtask

  task automatic test_scen_same_cycle();
    logic hit;
    hit = 1'b0;
    fork
      send_byte(8'h1D, 1'b0);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (rx_valid) begin
            hit = 1'b1;
            break;
          end
        end
        if (hit) begin
          SCEN = 1'b1;
          @(negedge clk);
          SCEN = 1'b0;
        end
      end
    join
    checks++;
    if (hit !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_rx_valid got=%b exp=1", hit);
    end
    checks++;
    if (outs !== 10'h000) begin
      failures++;
      $display("FAIL same_cycle_first_tick got=%h exp=000", outs);
    end
    frame_tick();
    checks++;
    if (outs !== 10'h004) begin
      failures++;
      $display("FAIL same_cycle_next_tick got=%h exp=004", outs);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    frame_tick();
    checks++;
    if (outs !== 10'h000) begin
      failures++;
      $display("FAIL jump_release got=%h exp=000", outs);
    end
  endtask

  task automatic test_parity_err();
    int rx0, err0;
    rx0 = rx_cnt;
    err0 = err_cnt;
    send_byte(8'h1D, 1'b1);
    checks++;
    if (err_cnt - err0 !== 1 || rx_cnt - rx0 !== 0) begin
      failures++;
      $display("FAIL parity_pulses err=%0d rx=%0d exp=1/0", err_cnt - err0, rx_cnt - rx0);
    end
    frame_tick();
    checks++;
    if (outs !== 10'h000) begin
      failures++;
      $display("FAIL parity_no_key got=%h exp=000", outs);
    end
    send_byte(8'h1D, 1'b0);
    frame_tick();
    checks++;
    if (outs !== 10'h004) begin
      failures++;
      $display("FAIL parity_recover got=%h exp=004", outs);
    end
  endtask

  task automatic test_timeout();
    int err0;
    err0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TO + 20) @(negedge clk);
    send_byte(8'h42, 1'b0);
    checks++;
    if (rx_byte !== 8'h42 || err_cnt !== err0) begin
      failures++;
      $display("FAIL timeout_recover rx_byte=%h errs=%0d exp=42/0", rx_byte, err_cnt - err0);
    end
    frame_tick();
    checks++;
    if (outs !== 10'h104) begin
      failures++;
      $display("FAIL timeout_keys got=%h exp=104", outs);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 10'h000 || rx_byte !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_state outs=%h rx_byte=%h exp=000/00", outs, rx_byte);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h4B, 1'b0);
    frame_tick();
    checks++;
    if (outs !== 10'h200 || rx_byte !== 8'h4B) begin
      failures++;
      $display("FAIL mid_reset_recover outs=%h rx_byte=%h exp=200/4b", outs, rx_byte);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_tap();
    test_scen_same_cycle();
    test_parity_err();
    test_timeout();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_input_decoder.md
# ps2_input_decoder

Front end of the fighter input path. Receives PS/2 Set-2 scancodes from a single shared keyboard and turns make/break codes into ten held-key levels, one per game_core player input (p1_left … p2_atk2). Key levels are frame-latched on SCEN, so the game logic sees inputs that are stable for a whole frame and never misses a tap.

## Interface
- TIMEOUT_CYCLES, 50000: idle clocks allowed between PS/2 falling edges inside a frame before the partial frame is dropped (1 ms at 50 MHz).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- SCEN  in  1  one-cycle frame-tick enable, shared with game_core.
- ps2_clk  in  1  raw PS/2 clock; asynchronous.
- ps2_data  in  1  raw PS/2 data; asynchronous.
- p1_left, p1_right, p1_jump, p1_atk1, p1_atk2  out  1 each  frame-latched P1 inputs.
- p2_left, p2_right, p2_jump, p2_atk1, p2_atk2  out  1 each  frame-latched P2 inputs.
- rx_byte  out  8  last correctly received byte.
- rx_valid  out  1  one-cycle pulse; rx_byte is new.
- frame_err  out  1  one-cycle pulse on a parity or stop-bit error.

## Operation
- Synchronise ps2_clk and ps2_data with two flops each. A falling edge is synced ps2_clk going from 1 to 0, registered. That makes a one-cycle sample strobe.
- Receive FSM, states IDLE and SHIFT. Bit counter runs 0..10.
  - IDLE: on a strobe with data=0 (start bit), go to SHIFT with count=1. Start bit = 1 is ignored and the FSM stays in IDLE.
  - SHIFT: counts 1–8 shift data in LSB first. Count 9 is odd parity. Count 10 is the stop bit; the FSM then returns to IDLE.
  - At count 10, if parity is odd over data+parity and stop=1, write rx_byte and pulse rx_valid. Otherwise pulse frame_err, discard the byte and clear the prefix state to P_NONE.
  - Watchdog counter clears on every strobe. In SHIFT, reaching TIMEOUT_CYCLES drops the partial frame: return to IDLE with no pulse. The counter saturates and does not wrap.
- Prefix FSM runs on rx_valid. States are P_NONE, P_E0, P_F0, P_E0F0.
  - E0: go to P_E0 from any state.
  - F0: P_NONE→P_F0, P_E0→P_E0F0. In P_F0 or P_E0F0, F0 holds the state.
  - Any other byte: form the event (ext = state∈{P_E0,P_E0F0}, brk = state∈{P_F0,P_E0F0}, code). Look the event up, then go to P_NONE.
- Key map, indexed 0..9 as listed:
  - P1: 1C (A) left, 23 (D) right, 1D (W) jump, 2B (F) atk1, 34 (G) atk2.
  - P2: E0 6B left, E0 74 right, E0 75 jump, 42 (K) atk1, 4B (L) atk2.
  - A code must match both value and ext flag. Plain 6B is not P2 left.
  - Unmapped codes, including the E1 pause sequence, are ignored.
- key_held[9:0]: set on make, clear on break. Typematic repeat makes are idempotent.
- key_seen[9:0]: sticky bit, set on make.
- On SCEN: outputs <= key_held | key_seen, using values registered before this cycle. Then key_seen is cleared.
  - A make arriving in the same cycle as SCEN stays set in key_seen and shows at the next SCEN.
  - A break arriving in the same cycle as SCEN clears key_held only after the sample.

## Timing
- Reset values, all registers: outputs 0, rx_byte=00, rx_valid=0, frame_err=0, key_held=0, key_seen=0, IDLE, P_NONE, counters 0. Synchroniser flops reset to 1, the PS/2 idle level. Reset mid-frame drops the frame.
- Pin falling edge to sample strobe: 3 clk.
- 11th strobe to rx_valid or frame_err: +1 clk.
- rx_valid to key_held/key_seen update: +1 clk.
- key state to outputs: the next SCEN, then +1 clk register.
- No backpressure: rx_valid is a pulse with no handshake.

## Test plan
- Reset, idle lines, 3 SCEN pulses → all ten outputs 0, rx_valid and frame_err never pulse.
- Send 1C then SCEN → p1_left=1 after the SCEN. Send F0 1C then SCEN → p1_left=0, rx_byte=1C.
- Send E0 6B then SCEN → p2_left=1. Send F0 E0? No: send E0 F0 6B then SCEN → p2_left=0. Send plain 6B then SCEN → all outputs 0.
- Send 23, F0 23 with both between two SCEN pulses → p1_right=1 for exactly one frame, 0 after the following SCEN. Make of 1D on the SCEN cycle → p1_jump appears at the following SCEN.
- Send 1D with a wrong parity bit → one frame_err pulse, no rx_valid, p1_jump stays 0. A good 1D next → p1_jump=1.
- Send 5 bits, idle TIMEOUT_CYCLES+1 clk, then a full 42 frame → rx_byte=42, p2_atk1=1 after SCEN. Assert reset during bit 4 → all outputs 0, and the next full frame decodes correctly.
